// File: rtl/treepram_pkg.sv
// rtl/treepram_pkg.sv - shared constants for the tree PRAM SoC: core count, bus width, entropy pool taps and seed.
package treepram_pkg;

   localparam int LOG_CORES       = 2;
   localparam int WB_WIDTH        = 32;
   localparam int DEF_SRC_WIDTH   = 16;
   localparam int DEF_READY_COUNT = 8;
   localparam int DEF_REP_LIMIT   = 15;

   // Feedback taps of x^32 + x^22 + x^2 + x + 1, as pool bit indices.
   localparam int POOL_TAP_A = 31;
   localparam int POOL_TAP_B = 21;
   localparam int POOL_TAP_C = 1;
   localparam int POOL_TAP_D = 0;

   localparam int POOL_SEED = 1;

endpackage

// File: rtl/entropy_health.sv
// rtl/entropy_health.sv - repetition-count health test on raw entropy samples; built only with ENTROPY_HEALTH_EN.
`ifdef ENTROPY_HEALTH_EN
module entropy_health #(
   parameter int SRC_WIDTH = 16,
   parameter int REP_LIMIT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SRC_WIDTH-1:0] sample,
   input  logic                 sample_valid,
   output logic                 fail
);

   localparam int REP_W = $clog2(REP_LIMIT + 1);

   logic [SRC_WIDTH-1:0] prev_q, prev_d;
   logic                 have_prev_q, have_prev_d;
   logic [REP_W-1:0]     rep_q, rep_d;
   logic                 fail_q, fail_d;

   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      rep_d       = rep_q;
      fail_d      = fail_q;
      if (sample_valid) begin
         prev_d      = sample;
         have_prev_d = 1'b1;
         // The first sample after reset has nothing to repeat, so it starts a run of one.
         if (have_prev_q && (sample == prev_q)) begin
            if (rep_q != REP_W'(REP_LIMIT))
               rep_d = rep_q + REP_W'(1);
         end else begin
            rep_d = REP_W'(1);
         end
         if (rep_d == REP_W'(REP_LIMIT))
            fail_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         rep_q       <= '0;
         fail_q      <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         rep_q       <= rep_d;
         fail_q      <= fail_d;
      end
   end

   assign fail = fail_q;

endmodule
`endif

// File: rtl/entropy_pool.sv
// rtl/entropy_pool.sv - LFSR entropy pool mixing raw samples, with ready counter; ENTROPY_HEALTH_EN adds the repetition test.
module entropy_pool
   import treepram_pkg::*;
#(
   parameter int WB_WIDTH    = treepram_pkg::WB_WIDTH,
   parameter int SRC_WIDTH   = DEF_SRC_WIDTH,
   parameter int READY_COUNT = DEF_READY_COUNT,
   parameter int REP_LIMIT   = DEF_REP_LIMIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SRC_WIDTH-1:0] src_bits,
   input  logic                 src_valid,
   input  logic                 entropy_read,
   output logic [WB_WIDTH-1:0]  entropy_word,
   output logic                 entropy_ready,
   output logic                 health_fail
);

   localparam int CNT_W = $clog2(READY_COUNT + 1);

   logic [WB_WIDTH-1:0] pool_q, pool_d;
   logic [WB_WIDTH-1:0] shifted, mixed;
   logic                fb;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   always_comb begin
      fb      = pool_q[POOL_TAP_A] ^ pool_q[POOL_TAP_B] ^ pool_q[POOL_TAP_C] ^ pool_q[POOL_TAP_D];
      shifted = {pool_q[WB_WIDTH-2:0], fb};
      mixed   = src_valid ? (shifted ^ WB_WIDTH'(src_bits)) : shifted;
      // An all-zero LFSR would stay stuck forever; reseed instead.
      pool_d  = (mixed == '0) ? WB_WIDTH'(POOL_SEED) : mixed;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (entropy_read)
         cnt_d = src_valid ? CNT_W'(1) : '0;
      else if (src_valid && (cnt_q != CNT_W'(READY_COUNT)))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pool_q <= WB_WIDTH'(POOL_SEED);
         cnt_q  <= '0;
      end else begin
         pool_q <= pool_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef ENTROPY_HEALTH_EN
   entropy_health #(
      .SRC_WIDTH (SRC_WIDTH),
      .REP_LIMIT (REP_LIMIT)
   ) u_health (
      .clk          (clk),
      .rst          (rst),
      .sample       (src_bits),
      .sample_valid (src_valid),
      .fail         (health_fail)
   );
`else
   assign health_fail = 1'b0;
`endif

   assign entropy_word  = pool_q;
   assign entropy_ready = (cnt_q == CNT_W'(READY_COUNT)) && !health_fail;

endmodule
